bmp_stream_reader: RTL

Synthesizable BMP byte-stream parser. It is the source-side counterpart of the BMP writer in the image-processing bench: it consumes a raw 24-bit uncompressed BMP file as a byte stream, validates and strips the 54-byte header, and removes row padding. It then emits RGB pixels with a valid/ready handshake to feed `img_processing` and downstream speed-detection stages.

---
 rtl/bmp_pkg.sv | 18 +
 rtl/bmp_header_decoder.sv | 60 ++++++
 rtl/bmp_stream_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared state type, header offsets and magic bytes for the BMP stream reader
package bmp_pkg;

  typedef enum logic [2:0] {HDR, PB, PG, PR, OUT, PAD, DONE, ERR} state_t;

  localparam logic [5:0] SIG_OFS    = 6'd0;
  localparam logic [5:0] OFFSET_OFS = 6'd10;
  localparam logic [5:0] WIDTH_OFS  = 6'd18;
  localparam logic [5:0] HEIGHT_OFS = 6'd22;
  localparam logic [5:0] BPP_OFS    = 6'd28;
  localparam logic [5:0] HDR_LEN    = 6'd54;
  localparam logic [5:0] HDR_LAST   = 6'd53;

  localparam logic [7:0] MAGIC_B = 8'd66;
  localparam logic [7:0] MAGIC_M = 8'd77;
  localparam logic [7:0] BPP_24  = 8'd24;

endpackage

// File: rtl/bmp_header_decoder.sv
// rtl/bmp_header_decoder.sv - captures width/height and validates the 54-byte BMP header
module bmp_header_decoder
  import bmp_pkg::*;
#(
  parameter int MAX_W = 1024,
  parameter int MAX_H = 1024,
  localparam int XW = $clog2(MAX_W),
  localparam int YW = $clog2(MAX_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    byte_data,
  input  logic          byte_strobe,
  input  logic [5:0]    byte_idx,
  output logic [XW:0]   width,
  output logic [YW:0]   height,
  output logic          hdr_ok
);

  logic [31:0] w32, h32;
  logic        fields_ok;

  // fields_ok re-arms on byte 0 and is knocked down by any mismatching fixed field
  always_ff @(posedge clk) begin
    if (reset) begin
      w32       <= '0;
      h32       <= '0;
      fields_ok <= 1'b0;
    end else if (byte_strobe) begin
      case (byte_idx)
        SIG_OFS:                  fields_ok <= (byte_data == MAGIC_B);
        SIG_OFS + 6'd1:           if (byte_data != MAGIC_M) fields_ok <= 1'b0;
        OFFSET_OFS:               if (byte_data != {2'b00, HDR_LEN}) fields_ok <= 1'b0;
        OFFSET_OFS + 6'd1,
        OFFSET_OFS + 6'd2,
        OFFSET_OFS + 6'd3,
        BPP_OFS + 6'd1:           if (byte_data != 8'd0) fields_ok <= 1'b0;
        BPP_OFS:                  if (byte_data != BPP_24) fields_ok <= 1'b0;
        WIDTH_OFS:                w32[7:0]   <= byte_data;
        WIDTH_OFS + 6'd1:         w32[15:8]  <= byte_data;
        WIDTH_OFS + 6'd2:         w32[23:16] <= byte_data;
        WIDTH_OFS + 6'd3:         w32[31:24] <= byte_data;
        HEIGHT_OFS:               h32[7:0]   <= byte_data;
        HEIGHT_OFS + 6'd1:        h32[15:8]  <= byte_data;
        HEIGHT_OFS + 6'd2:        h32[23:16] <= byte_data;
        HEIGHT_OFS + 6'd3:        h32[31:24] <= byte_data;
        default: ;
      endcase
    end
  end

  // Unsigned 32-bit compare: a top-down (negative) height lands far above MAX_H
  assign hdr_ok = fields_ok
                && (w32 != 32'd0) && (w32 <= 32'(MAX_W))
                && (h32 != 32'd0) && (h32 <= 32'(MAX_H));

  assign width  = w32[XW:0];
  assign height = h32[YW:0];

endmodule

// File: rtl/bmp_stream_reader.sv
// rtl/bmp_stream_reader.sv - 24-bit BMP byte stream to RGB pixel stream; BMP_READER_GRAY_EN adds data_grayscale
module bmp_stream_reader
  import bmp_pkg::*;
#(
  parameter int MAX_W = 1024,
  parameter int MAX_H = 1024,
  localparam int XW = $clog2(MAX_W),
  localparam int YW = $clog2(MAX_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          eol,
  output logic [XW:0]   width,
  output logic [YW:0]   height,
  output logic          done,
  output logic          err
`ifdef BMP_READER_GRAY_EN
  ,output logic [7:0]   data_grayscale
`endif
);

  localparam logic [XW:0] ONE_X = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0] ONE_Y = {{YW{1'b0}}, 1'b1};

  state_t      state, next_state;
  logic [5:0]  hdr_cnt;
  logic [1:0]  pad_cnt;
  logic [1:0]  pad;
  logic [7:0]  b_stage, g_stage;
  logic        last_row_q;
  logic        in_fire;
  logic        at_last_row;
  logic        hdr_ok;
  logic [XW:0] dec_width;
  logic [YW:0] dec_height;

  bmp_header_decoder #(.MAX_W(MAX_W), .MAX_H(MAX_H)) u_hdr (
    .clk         (clk),
    .reset       (reset),
    .byte_data   (in_data),
    .byte_strobe (in_fire && (state == HDR)),
    .byte_idx    (hdr_cnt),
    .width       (dec_width),
    .height      (dec_height),
    .hdr_ok      (hdr_ok)
  );

  // 3*width bytes per row pad to a multiple of 4 exactly when adding width mod 4
  assign pad         = width[1:0];
  assign in_fire     = in_valid && in_ready;
  assign at_last_row = ({1'b0, y} == (height - ONE_Y));

  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    pix_valid  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      HDR: begin
        in_ready = 1'b1;
        if (in_fire && (hdr_cnt == HDR_LAST)) next_state = hdr_ok ? PB : ERR;
      end
      PB: begin
        in_ready = 1'b1;
        if (in_fire) next_state = PG;
      end
      PG: begin
        in_ready = 1'b1;
        if (in_fire) next_state = PR;
      end
      PR: begin
        in_ready = 1'b1;
        if (in_fire) next_state = OUT;
      end
      OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          if (!eol)             next_state = PB;
          else if (pad != 2'd0) next_state = PAD;
          else if (at_last_row) next_state = DONE;
          else                  next_state = PB;
        end
      end
      PAD: begin
        in_ready = 1'b1;
        if (in_fire && (pad_cnt == (pad - 2'd1))) next_state = last_row_q ? DONE : PB;
      end
      DONE: done = 1'b1;
      ERR:  err  = 1'b1;
      default: next_state = HDR;
    endcase
  end

  // x/y double as the position counters; they advance on each pixel handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_cnt    <= '0;
      pad_cnt    <= '0;
      b_stage    <= '0;
      g_stage    <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      x          <= '0;
      y          <= '0;
      eol        <= 1'b0;
      width      <= '0;
      height     <= '0;
      last_row_q <= 1'b0;
`ifdef BMP_READER_GRAY_EN
      data_grayscale <= '0;
`endif
    end else begin
      case (state)
        HDR: if (in_fire) begin
          hdr_cnt <= hdr_cnt + 6'd1;
          if ((hdr_cnt == HDR_LAST) && hdr_ok) begin
            width  <= dec_width;
            height <= dec_height;
          end
        end
        PB: if (in_fire) b_stage <= in_data;
        PG: if (in_fire) g_stage <= in_data;
        PR: if (in_fire) begin
          red   <= in_data;
          green <= g_stage;
          blue  <= b_stage;
          eol   <= ({1'b0, x} == (width - ONE_X));
`ifdef BMP_READER_GRAY_EN
          data_grayscale <= {2'b00, in_data[7:2]} + {1'b0, g_stage[7:1]} + {2'b00, b_stage[7:2]};
`endif
        end
        OUT: if (pix_ready) begin
          if (eol) begin
            x          <= '0;
            pad_cnt    <= '0;
            last_row_q <= at_last_row;
            if (!at_last_row) y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        PAD: if (in_fire) pad_cnt <= pad_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule
